// File: rtl/flash_logger_pkg.sv
// flash_logger_pkg: bus FSM state encoding and default flash address window for flash_logger.
package flash_logger_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        GAP    = 2'd2,
        VERIFY = 2'd3
    } state_t;
    localparam logic [15:0] DEFAULT_BASE  = 16'd64;
    localparam logic [15:0] DEFAULT_LIMIT = 16'hFFFF;
endpackage

// File: rtl/flash_logger_fifo.sv
// flash_logger_fifo: synchronous first-word-fall-through FIFO with flush; depth 2**AW.
module flash_logger_fifo #(
    parameter int AW = 4,
    parameter int W  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wp, rp;
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head  = mem[rp[AW-1:0]];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + {{AW{1'b0}}, push && !full};
            rp <= rp + {{AW{1'b0}}, pop && !empty};
        end
    always_ff @(posedge clk)
        if (push && !full && !flush) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/flash_logger.sv
// flash_logger: buffers a 16-bit sample stream and writes it to consecutive flash words over
// Wishbone; defining FLASH_LOGGER_VERIFY_EN adds a read-back check after every write.
module flash_logger
    import flash_logger_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = DEFAULT_BASE,
    parameter logic [15:0] LIMIT_ADDR = DEFAULT_LIMIT,
    parameter int          FIFO_AW    = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        enable_i,
    input  logic        clear_i,
    input  logic [15:0] sample_i,
    input  logic        sample_vld_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [15:0] wbm_adr_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic [15:0] wr_ptr_o,
    output logic        region_full_o,
    output logic        overflow_o,
    output logic        busy_o,
    output logic        verify_err_o
);
    state_t      state;
    logic        clear_pend, apply_clear, push, start, fifo_full, fifo_empty;
    logic [15:0] head;
    // a clear never cuts a transaction short: it waits until the bus is between cycles
    assign apply_clear = (state == IDLE || state == GAP) && (clear_i || clear_pend);
    assign push        = sample_vld_i && !fifo_full && !region_full_o && !apply_clear;
    assign start       = state == IDLE && enable_i && !fifo_empty && !region_full_o && !apply_clear;
    assign busy_o      = state != IDLE || !fifo_empty;
    flash_logger_fifo #(.AW(FIFO_AW), .W(16)) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .flush (apply_clear),
        .push  (push),
        .pop   (start),
        .din   (sample_i),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            state         <= IDLE;
            clear_pend    <= 1'b0;
            wbm_cyc_o     <= 1'b0;
            wbm_stb_o     <= 1'b0;
            wbm_we_o      <= 1'b0;
            wbm_adr_o     <= '0;
            wbm_dat_o     <= '0;
            wr_ptr_o      <= BASE_ADDR;
            region_full_o <= 1'b0;
            overflow_o    <= 1'b0;
        end else begin
            if (sample_vld_i && !push && !apply_clear) overflow_o <= 1'b1;
            if (clear_i && !apply_clear) clear_pend <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    wbm_we_o  <= 1'b1;
                    wbm_adr_o <= wr_ptr_o;
                    wbm_dat_o <= head;
                    state     <= WRITE;
                end
                WRITE: if (wbm_ack_i) begin
                    wbm_cyc_o     <= 1'b0;
                    wbm_stb_o     <= 1'b0;
                    wbm_we_o      <= 1'b0;
                    wr_ptr_o      <= (wr_ptr_o == LIMIT_ADDR) ? wr_ptr_o : wr_ptr_o + 16'd1;
                    region_full_o <= region_full_o || wr_ptr_o == LIMIT_ADDR;
`ifdef FLASH_LOGGER_VERIFY_EN
                    state         <= VERIFY;
`else
                    state         <= GAP;
`endif
                end
`ifdef FLASH_LOGGER_VERIFY_EN
                VERIFY: if (!wbm_cyc_o) begin
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                end else if (wbm_ack_i) begin
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    state     <= GAP;
                end
`endif
                default: state <= IDLE;
            endcase
            if (apply_clear) begin
                clear_pend    <= 1'b0;
                wr_ptr_o      <= BASE_ADDR;
                region_full_o <= 1'b0;
                overflow_o    <= 1'b0;
            end
        end
`ifdef FLASH_LOGGER_VERIFY_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) verify_err_o <= 1'b0;
        else if (apply_clear) verify_err_o <= 1'b0;
        else if (state == VERIFY && wbm_cyc_o && wbm_ack_i && wbm_dat_i != wbm_dat_o) verify_err_o <= 1'b1;
`else
    logic unused_dat;
    assign unused_dat   = ^wbm_dat_i;
    assign verify_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_flash_logger.sv
// tb_flash_logger: directed stimulus, a queue-based model of the logger checked every cycle,
// and literal expectations for the scenarios of interest.
module tb_flash_logger;
    localparam logic [15:0] LIMIT = 16'd1100;
    logic clk = 0, rst = 1, enable = 1, clear = 0, vld = 0, ack = 0;
    logic [15:0] sample = 0, rdat = 0;
    logic cyc, stb, we, full, ovf, busy, verr;
    logic [15:0] adr, wdat, wr_ptr;
    int passed = 0, total = 0;
    int lat = 3, wcnt = 0, nwrites = 0, nreads = 0, nwstart = 0;
    bit corrupt = 0, prev_wcyc = 0;
    logic [15:0] mem [0:65535];
    logic [15:0] q [$];
    logic [15:0] m_ptr = 16'd64, last_a = 16'd0;
    bit m_full = 0, m_ovf = 0, m_verr = 0, pend = 0, vphase = 0;
    bit apply, acc, wack, rack;

    always #5 clk = ~clk;

    flash_logger #(.BASE_ADDR(16'd64), .LIMIT_ADDR(LIMIT), .FIFO_AW(4)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .enable_i      (enable),
        .clear_i       (clear),
        .sample_i      (sample),
        .sample_vld_i  (vld),
        .wbm_cyc_o     (cyc),
        .wbm_stb_o     (stb),
        .wbm_we_o      (we),
        .wbm_adr_o     (adr),
        .wbm_dat_o     (wdat),
        .wbm_dat_i     (rdat),
        .wbm_ack_i     (ack),
        .wr_ptr_o      (wr_ptr),
        .region_full_o (full),
        .overflow_o    (ovf),
        .busy_o        (busy),
        .verify_err_o  (verr)
    );

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0d expected %0d", n, a, e);
    endtask

    // Flash-side responder: acks after lat cycles, records writes, serves reads.
    always @(negedge clk) begin
        if (cyc && stb && !ack) begin
            wcnt++;
            if (wcnt >= lat) begin
                ack = 1;
                if (we) begin
                    mem[adr] = wdat;
                    nwrites++;
                end else begin
                    rdat = mem[adr] ^ ((corrupt && adr == 16'd70) ? 16'h0001 : 16'h0000);
                    nreads++;
                end
            end
        end else begin
            ack = 0;
            wcnt = 0;
        end
    end

    // Model: queue of accepted-but-unacknowledged words; capacity grows by one while a word is on the bus.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ptr = 16'd64; m_full = 0; m_ovf = 0; m_verr = 0; pend = 0; vphase = 0;
        end else begin
            apply = (clear || pend) && !cyc && !vphase;
            pend = !apply && (pend || clear);
            wack = cyc && we && ack;
            rack = cyc && !we && ack;
            acc = vld && !apply && !m_full && q.size() < 16 + int'(cyc && we);
            if (vld && !acc && !apply) m_ovf = 1;
            if (acc) q.push_back(sample);
            if (wack) begin
                last_a = m_ptr;
                if (q.size() > 0) void'(q.pop_front());
                if (m_ptr == LIMIT) m_full = 1;
                else m_ptr = m_ptr + 16'd1;
`ifdef FLASH_LOGGER_VERIFY_EN
                vphase = 1;
`endif
            end
            if (rack) begin
                if (corrupt && last_a == 16'd70) m_verr = 1;
                vphase = 0;
            end
            if (apply) begin
                q.delete();
                m_ptr = 16'd64; m_full = 0; m_ovf = 0; m_verr = 0;
            end
        end
    end

    always @(negedge clk) if (!rst) begin
        chk("wr_ptr", int'(wr_ptr), int'(m_ptr));
        chk("region_full", int'(full), int'(m_full));
        chk("overflow", int'(ovf), int'(m_ovf));
        chk("verify_err", int'(verr), int'(m_verr));
        chk("stb_eq_cyc", int'(stb), int'(cyc));
        if (cyc && we) begin
            chk("write_allowed", int'(q.size() > 0 && !m_full), 1);
            if (q.size() > 0) begin
                chk("wr_adr", int'(adr), int'(m_ptr));
                chk("wr_dat", int'(wdat), int'(q[0]));
            end
        end
        if (cyc && !we) begin
`ifdef FLASH_LOGGER_VERIFY_EN
            chk("rd_adr", int'(adr), int'(last_a));
`else
            chk("no_read", int'(we), 1);
`endif
        end
        if (cyc && we && !prev_wcyc) nwstart++;
        prev_wcyc = cyc && we;
    end

    task automatic send(input int first, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample = 16'(first + i);
            vld = 1;
            repeat (gap - 1) begin
                @(negedge clk);
                vld = 0;
            end
        end
        @(negedge clk);
        vld = 0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk("drain_timeout", int'(busy), 0);
    endtask

    task automatic wait_cyc(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cyc) return;
        end
        chk("cyc_timeout", int'(cyc), 1);
    endtask

    task automatic pulse_clear;
        @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cyc", int'(cyc), 0);
        chk("rst_stb", int'(stb), 0);
        chk("rst_we", int'(we), 0);
        chk("rst_adr", int'(adr), 0);
        chk("rst_dat", int'(wdat), 0);
        chk("rst_ptr", int'(wr_ptr), 64);
        chk("rst_full", int'(full), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_verr", int'(verr), 0);
        rst = 0;
        send(0, 1000, 20);
        drain(200);
        chk("s1_ptr", int'(wr_ptr), 1064);
        chk("s1_ovf", int'(ovf), 0);
        chk("s1_first", int'(mem[64]), 0);
        chk("s1_mid", int'(mem[564]), 500);
        chk("s1_last", int'(mem[1063]), 999);
        chk("s1_writes", nwrites, 1000);
        pulse_clear;
        chk("clr_ptr", int'(wr_ptr), 64);
        lat = 850;
        nwrites = 0;
        send(2000, 40, 1);
        chk("burst_ovf", int'(ovf), 1);
        drain(40000);
        chk("burst_writes", nwrites, 17);
        chk("burst_ptr", int'(wr_ptr), 81);
        chk("burst_first", int'(mem[64]), 2000);
        chk("burst_last", int'(mem[80]), 2016);
        lat = 10;
        nwrites = 0;
        nwstart = 0;
        send(4660, 2, 1);
        pulse_clear;
        chk("clr_cyc_held", int'(cyc), 1);
        drain(100);
        chk("clrw_writes", nwrites, 1);
        chk("clrw_starts", nwstart, 1);
        chk("clrw_word", int'(mem[81]), 4660);
        chk("clrw_ptr", int'(wr_ptr), 64);
        chk("clrw_ovf", int'(ovf), 0);
        chk("clrw_busy", int'(busy), 0);
        lat = 1;
        send(0, 1035, 6);
        drain(200);
        chk("lim_pre_ptr", int'(wr_ptr), 1099);
        chk("lim_pre_full", int'(full), 0);
        nwrites = 0;
        send(160, 4, 1);
        repeat (40) @(negedge clk);
        chk("lim_full", int'(full), 1);
        chk("lim_ptr", int'(wr_ptr), 1100);
        chk("lim_busy", int'(busy), 1);
        chk("lim_writes", nwrites, 2);
        chk("lim_w1099", int'(mem[1099]), 160);
        chk("lim_w1100", int'(mem[1100]), 161);
        chk("lim_ovf0", int'(ovf), 0);
        send(170, 1, 1);
        chk("lim_ovf1", int'(ovf), 1);
        pulse_clear;
        chk("lim_clr_ptr", int'(wr_ptr), 64);
        chk("lim_clr_full", int'(full), 0);
        chk("lim_clr_ovf", int'(ovf), 0);
        chk("lim_clr_busy", int'(busy), 0);
        send(500, 1, 1);
        drain(50);
        chk("pre_rst_ptr", int'(wr_ptr), 65);
        lat = 50;
        send(501, 1, 1);
        wait_cyc(10);
        repeat (3) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst_cyc", int'(cyc), 0);
        chk("arst_stb", int'(stb), 0);
        @(negedge clk);
        chk("arst_we", int'(we), 0);
        chk("arst_adr", int'(adr), 0);
        chk("arst_dat", int'(wdat), 0);
        chk("arst_ptr", int'(wr_ptr), 64);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ovf", int'(ovf), 0);
        rst = 0;
        lat = 2;
        corrupt = 1;
        nreads = 0;
        send(768, 6, 20);
        drain(100);
        chk("ver_clean", int'(verr), 0);
        send(774, 4, 20);
        drain(100);
        chk("ver_ptr", int'(wr_ptr), 74);
`ifdef FLASH_LOGGER_VERIFY_EN
        chk("ver_err", int'(verr), 1);
        chk("ver_reads", nreads, 10);
`else
        chk("ver_err", int'(verr), 0);
        chk("ver_reads", nreads, 0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
